// File: rtl/fc_wgt_tiler_if.sv
// Serial weight input and tile output of the FC weight tiler.
// Pure wiring: no latency, no storage.
// in_valid/in_ready handshake on input; wgt_read_fc request / wgt_valid response on output.
interface fc_wgt_tiler_if #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int TILING       = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [WEIGHT_WIDTH-1:0]        in_data;
  logic                           wgt_read_fc;
  logic [TILING*WEIGHT_WIDTH-1:0] wgt_fc;
  logic                           wgt_valid;

  // Weight source and FC engine side
  modport master (
    output in_valid, in_data, wgt_read_fc,
    input  in_ready, wgt_fc, wgt_valid
  );

  // Tiler side
  modport slave (
    input  in_valid, in_data, wgt_read_fc,
    output in_ready, wgt_fc, wgt_valid
  );
endinterface

// File: rtl/fc_wgt_tiler.sv
// Packs TILING serial weights per tile into a DEPTH-entry FIFO and serves one tile per wgt_read_fc.
// Latency: tile appears on wgt_fc/wgt_valid one cycle after the accepted request.
// Backpressure: in_ready drops on the last word of a tile while the FIFO is full (registered state only).
// Optional macro FC_WGT_TILER_CHK_EN adds chk_sum, the XOR of every delivered tile.
module fc_wgt_tiler #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int TILING       = 8,
  parameter int IN_FEATURE   = 2304,
  parameter int OUT_FEATURE  = 2048,
  parameter int DEPTH        = 4
) (
  input  logic                clk2,
  input  logic                rst_n,
  input  logic                start,
  fc_wgt_tiler_if.slave       bus,
  output logic                underrun,
  output logic                busy,
  output logic                done
`ifdef FC_WGT_TILER_CHK_EN
  ,
  output logic [TILING*WEIGHT_WIDTH-1:0] chk_sum
`endif
);

  localparam int TW          = TILING * WEIGHT_WIDTH;
  localparam int TOTAL_TILES = (IN_FEATURE * OUT_FEATURE) / TILING;
  localparam int IW          = (TILING > 1) ? $clog2(TILING) : 1;
  localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW          = $clog2(DEPTH + 1);

  // A layer whose weight count is not a whole number of tiles cannot be streamed.
  if (((IN_FEATURE * OUT_FEATURE) % TILING) != 0) begin : g_bad_tiling
    $error("fc_wgt_tiler: IN_FEATURE*OUT_FEATURE is not a multiple of TILING");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fc_wgt_tiler: DEPTH must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            in_ready_c;
  logic            done_d;

  logic [IW-1:0]   word_idx;
  logic [TW-1:0]   tile_buf;
  logic [TW-1:0]   pack_dat;
  logic [31:0]     tiles_in;
  logic [31:0]     tiles_out;

  logic [TW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;

  logic            last_word;
  logic            fifo_full;
  logic            fifo_empty;
  logic            in_xfer;
  logic            push;
  logic            pop;
  logic            clr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign last_word  = (word_idx == IW'(TILING - 1));
  assign fifo_full  = (fifo_cnt == CW'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign in_xfer    = bus.in_valid && in_ready_c;
  assign push       = in_xfer && last_word;
  // An empty FIFO never serves, even when a tile is pushed in the same cycle.
  assign pop        = bus.wgt_read_fc && !fifo_empty;
  // Starting a layer from IDLE wipes everything left from the previous one.
  assign clr        = (state_q == S_IDLE) && start;

  assign bus.in_ready = in_ready_c;
  assign busy         = (state_q != S_IDLE);

  // State register
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, input readiness and end-of-layer detection
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready_c = !(last_word && fifo_full);
        if (push && (tiles_in == 32'(TOTAL_TILES - 1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (tiles_out == 32'(TOTAL_TILES - 1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Current tile with the incoming word dropped into its lane (word 0 in the LSBs)
  always_comb begin
    pack_dat = tile_buf;
    for (int k = 0; k < TILING; k++) begin
      if (word_idx == IW'(k)) pack_dat[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bus.in_data;
    end
  end

  // Packer: word index, partial tile and tiles-in counter
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      tile_buf <= '0;
      tiles_in <= '0;
    end else if (clr) begin
      word_idx <= '0;
      tile_buf <= '0;
      tiles_in <= '0;
    end else if (in_xfer) begin
      tile_buf <= pack_dat;
      if (last_word) begin
        word_idx <= '0;
        tiles_in <= tiles_in + 32'd1;
      end else begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // Tile storage; contents are qualified by the pointers and count, so no reset is needed
  always_ff @(posedge clk2) begin
    if (push) mem[wr_ptr] <= pack_dat;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Consumer: registered tile output, delivery counter, sticky underrun and done pulse
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      bus.wgt_fc    <= '0;
      bus.wgt_valid <= 1'b0;
      tiles_out     <= '0;
      underrun      <= 1'b0;
      done          <= 1'b0;
    end else begin
      bus.wgt_fc    <= pop ? mem[rd_ptr] : '0;
      bus.wgt_valid <= pop;
      done          <= done_d;
      if (clr) begin
        tiles_out <= '0;
        underrun  <= 1'b0;
      end else begin
        if (pop) tiles_out <= tiles_out + 32'd1;
        if (bus.wgt_read_fc && fifo_empty) underrun <= 1'b1;
      end
    end
  end

`ifdef FC_WGT_TILER_CHK_EN
  // Running XOR of delivered tiles, updated alongside wgt_valid
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n)   chk_sum <= '0;
    else if (clr) chk_sum <= '0;
    else if (pop) chk_sum <= chk_sum ^ mem[rd_ptr];
  end
`endif

endmodule
